// File: rtl/secuenciador_pkg.sv
// Shared definitions for the credit sequencer.
// Holds the stage count, the default credit ceiling, the FSM encoding and
// the stage-advance helper used by the top level.
package secuenciador_pkg;

  localparam int N_ESTADOS       = 6;
  localparam int MAX_CREDITO_DEF = 15;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    LISTO  = 2'd1,
    AVANCE = 2'd2
  } fsm_e;

  // Next stage index with wrap-around; anything at or above the last stage
  // returns to 0 so the index can never escape the legal range.
  function automatic logic [2:0] siguiente_estado(input logic [2:0] e);
    return (e >= 3'(N_ESTADOS - 1)) ? 3'd0 : e + 3'd1;
  endfunction

endpackage

// File: rtl/secuenciador_credito_if.sv
// Signal bundle between the credit sequencer and its environment.
//   moneda, boton_avance, cancelar : raw asynchronous inputs to the sequencer
//   estado, avance, credito, creditos : registered sequencer outputs
// master = environment side, slave = sequencer side.
interface secuenciador_credito_if;
  logic       moneda;
  logic       boton_avance;
  logic       cancelar;
  logic [2:0] estado;
  logic       avance;
  logic       credito;
  logic [3:0] creditos;

  modport master (
    output moneda, boton_avance, cancelar,
    input  estado, avance, credito, creditos
  );

  modport slave (
    input  moneda, boton_avance, cancelar,
    output estado, avance, credito, creditos
  );
endinterface

// File: rtl/antirrebote.sv
// Two-flop synchronizer, counter-based debouncer and rising-edge detector.
//   clk, rst  : clock and synchronous active-high reset
//   raw_i     : raw asynchronous level
//   flanco_o  : one-cycle pulse when the debounced level rises
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic flanco_o
);

  localparam logic [7:0] CNT_FIN = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       nivel_q;
  logic       flanco_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      nivel_q  <= 1'b0;
      flanco_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      flanco_q <= 1'b0;
      if (sync2_q != nivel_q) begin
        // cnt_q holds the number of earlier disagreeing samples, so this
        // sample is the DEBOUNCE_CYCLES-th one when it reaches CNT_FIN.
        if (cnt_q == CNT_FIN) begin
          nivel_q  <= sync2_q;
          flanco_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign flanco_o = flanco_q;

endmodule

// File: rtl/secuenciador_credito.sv
// Coin-credit stage sequencer.
// Coins add credit (saturating); each accepted advance press spends one
// credit, emits a one-cycle avance pulse and steps estado 0..5 with wrap.
//   clk, rst : clock and synchronous active-high reset
//   sec_if   : slave side of secuenciador_credito_if
//              (moneda, boton_avance, cancelar in; estado, avance,
//               credito, creditos out)
module secuenciador_credito
  import secuenciador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_CREDITO     = MAX_CREDITO_DEF
) (
  input logic                   clk,
  input logic                   rst,
  secuenciador_credito_if.slave sec_if
);

  localparam logic [3:0] MAX_C = 4'(MAX_CREDITO);

  logic       ev_moneda;
  logic       ev_avance;
  logic       canc1_q;
  logic       canc2_q;
  fsm_e       fsm_q;
  logic [2:0] estado_q;
  logic       avance_q;
  logic       credito_q;
  logic [3:0] creditos_q;
  logic [3:0] cred_mas_d;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_moneda (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (sec_if.moneda),
    .flanco_o (ev_moneda)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_avance (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (sec_if.boton_avance),
    .flanco_o (ev_avance)
  );

  // Cancel needs no debounce, only synchronization.
  always_ff @(posedge clk) begin
    if (rst) begin
      canc1_q <= 1'b0;
      canc2_q <= 1'b0;
    end else begin
      canc1_q <= sec_if.cancelar;
      canc2_q <= canc1_q;
    end
  end

  // Credit count after one coin, held at the ceiling.
  always_comb begin
    cred_mas_d = (creditos_q >= MAX_C) ? creditos_q : creditos_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= REPOSO;
      estado_q   <= '0;
      avance_q   <= 1'b0;
      credito_q  <= 1'b0;
      creditos_q <= '0;
    end else begin
      avance_q <= 1'b0;
      if (canc2_q) begin
        fsm_q      <= REPOSO;
        estado_q   <= '0;
        credito_q  <= 1'b0;
        creditos_q <= '0;
      end else begin
        case (fsm_q)
          REPOSO: begin
            // Advance requests without credit are simply ignored.
            if (ev_moneda) begin
              creditos_q <= 4'd1;
              credito_q  <= 1'b1;
              fsm_q      <= LISTO;
            end
          end
          LISTO: begin
            if (ev_avance) begin
              // A coin on the same edge pays for this advance: net zero.
              if (!ev_moneda) begin
                creditos_q <= creditos_q - 4'd1;
              end
              avance_q  <= 1'b1;
              credito_q <= 1'b1;
              fsm_q     <= AVANCE;
            end else if (ev_moneda) begin
              creditos_q <= cred_mas_d;
              credito_q  <= 1'b1;
            end
          end
          AVANCE: begin
            // estado changes only when leaving AVANCE, so the pulse is seen
            // together with the pre-advance stage.
            estado_q <= siguiente_estado(estado_q);
            if (ev_moneda) begin
              creditos_q <= cred_mas_d;
              credito_q  <= 1'b1;
              fsm_q      <= LISTO;
            end else begin
              credito_q <= (creditos_q != 4'd0);
              fsm_q     <= (creditos_q != 4'd0) ? LISTO : REPOSO;
            end
          end
          default: begin
            fsm_q <= REPOSO;
          end
        endcase
      end
    end
  end

  assign sec_if.estado   = estado_q;
  assign sec_if.avance   = avance_q;
  assign sec_if.credito  = credito_q;
  assign sec_if.creditos = creditos_q;

endmodule

// File: tb/tb_secuenciador_credito.sv
module tb_secuenciador_credito;

  logic clk = 1'b0;
  logic rst = 1'b1;

  secuenciador_credito_if bus ();

  secuenciador_credito #(
    .DEBOUNCE_CYCLES (4),
    .MAX_CREDITO     (15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sec_if (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: credits and stage as plain integers.
  int m_cred = 0;
  int m_est  = 0;

  // Advance-pulse monitor.
  int   pulsos = 0;
  int   pulso_estado = 0;
  logic pulso_credito = 1'b0;
  logic estado_malo = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.avance === 1'b1) begin
      pulsos++;
      pulso_estado  = int'(bus.estado);
      pulso_credito = bus.credito;
    end
    if (!rst && bus.estado > 3'd5) estado_malo = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_cancel();
    bus.cancelar = 1'b1;
    tick(3);
    bus.cancelar = 1'b0;
    tick(3);
    m_cred = 0;
    m_est  = 0;
  endtask

  // tipo: 0 coin, 1 advance press, 2 both together. Bouncy start, clean hold.
  task automatic do_op(input int tipo);
    int   rebote, alto, bajo, exp_pulsos, exp_est_pulso;
    logic mon, btn;
    rebote = $urandom_range(0, 5);
    alto   = $urandom_range(5, 9);
    bajo   = $urandom_range(8, 12);
    mon    = (tipo == 0 || tipo == 2);
    btn    = (tipo == 1 || tipo == 2);
    exp_pulsos    = 0;
    exp_est_pulso = m_est;
    case (tipo)
      0: m_cred = (m_cred < 15) ? m_cred + 1 : 15;
      1: if (m_cred > 0) begin
           exp_pulsos = 1;
           m_cred--;
           m_est = (m_est + 1) % 6;
         end
      default: if (m_cred > 0) begin
           exp_pulsos = 1;
           m_est = (m_est + 1) % 6;
         end else begin
           m_cred = 1;
         end
    endcase
    pulsos = 0;
    for (int i = 0; i < rebote; i++) begin
      bus.moneda       = mon & (i % 2 == 0);
      bus.boton_avance = btn & (i % 2 == 0);
      tick(1);
    end
    bus.moneda       = mon;
    bus.boton_avance = btn;
    tick(alto);
    bus.moneda       = 1'b0;
    bus.boton_avance = 1'b0;
    tick(bajo);
    n_cmp++;
    if (pulsos !== exp_pulsos) begin
      n_err++;
      $display("FAIL op%0d pulse count: got %0d expected %0d", tipo, pulsos, exp_pulsos);
    end
    if (exp_pulsos == 1) begin
      n_cmp++;
      if (pulso_estado !== exp_est_pulso) begin
        n_err++;
        $display("FAIL op%0d estado during avance: got %0d expected %0d", tipo, pulso_estado, exp_est_pulso);
      end
      n_cmp++;
      if (pulso_credito !== 1'b1) begin
        n_err++;
        $display("FAIL op%0d credito during avance: got %0b expected 1", tipo, pulso_credito);
      end
    end
    n_cmp++;
    if (bus.creditos !== 4'(m_cred)) begin
      n_err++;
      $display("FAIL op%0d creditos: got %0d expected %0d", tipo, bus.creditos, m_cred);
    end
    n_cmp++;
    if (bus.credito !== (m_cred != 0)) begin
      n_err++;
      $display("FAIL op%0d credito: got %0b expected %0b", tipo, bus.credito, (m_cred != 0));
    end
    n_cmp++;
    if (bus.estado !== 3'(m_est)) begin
      n_err++;
      $display("FAIL op%0d estado: got %0d expected %0d", tipo, bus.estado, m_est);
    end
    $display("op tipo=%0d creditos=%0d estado=%0d pulsos=%0d", tipo, bus.creditos, bus.estado, pulsos);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if ({bus.estado, bus.avance, bus.credito, bus.creditos} !== 9'd0) begin
      n_err++;
      $display("FAIL reset outputs: got estado=%0d avance=%0b credito=%0b creditos=%0d expected all 0",
               bus.estado, bus.avance, bus.credito, bus.creditos);
    end
    rst = 1'b0;
    tick(2);
    $display("test_reset done");
  endtask

  task automatic test_moneda_limpia();
    int lat;
    int maxc;
    lat  = 0;
    maxc = 0;
    bus.moneda = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (bus.credito === 1'b1 && lat == 0) lat = i;
      if (int'(bus.creditos) > maxc) maxc = int'(bus.creditos);
    end
    bus.moneda = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (int'(bus.creditos) > maxc) maxc = int'(bus.creditos);
    end
    m_cred = 1;
    n_cmp++;
    if (lat == 0) begin
      n_err++;
      $display("FAIL clean coin latency: got no credito within 8 cycles expected credito=1");
    end
    n_cmp++;
    if (maxc !== 1 || bus.creditos !== 4'd1) begin
      n_err++;
      $display("FAIL clean coin count: got max=%0d final=%0d expected 1", maxc, bus.creditos);
    end
    $display("test_moneda_limpia latency=%0d creditos=%0d", lat, bus.creditos);
  endtask

  task automatic test_rebote();
    do_cancel();
    for (int i = 0; i < 10; i++) begin
      bus.moneda = ~bus.moneda;
      tick(2);
    end
    bus.moneda = 1'b0;
    tick(12);
    n_cmp++;
    if (bus.creditos !== 4'd0 || bus.credito !== 1'b0) begin
      n_err++;
      $display("FAIL bounce rejected: got creditos=%0d credito=%0b expected 0", bus.creditos, bus.credito);
    end
    $display("test_rebote creditos=%0d", bus.creditos);
  endtask

  task automatic test_avance();
    do_cancel();
    do_op(0);
    do_op(0);
    do_op(1);
    n_cmp++;
    if (bus.estado !== 3'd1 || bus.creditos !== 4'd1) begin
      n_err++;
      $display("FAIL first advance: got estado=%0d creditos=%0d expected 1 1", bus.estado, bus.creditos);
    end
    do_op(1);
    n_cmp++;
    if (bus.estado !== 3'd2 || bus.creditos !== 4'd0 || bus.credito !== 1'b0) begin
      n_err++;
      $display("FAIL second advance: got estado=%0d creditos=%0d credito=%0b expected 2 0 0",
               bus.estado, bus.creditos, bus.credito);
    end
    do_op(1);
    $display("test_avance estado=%0d", bus.estado);
  endtask

  task automatic test_saturacion_vuelta();
    do_cancel();
    for (int i = 0; i < 5; i++) do_op(0);
    for (int i = 0; i < 5; i++) do_op(1);
    for (int i = 0; i < 17; i++) do_op(0);
    n_cmp++;
    if (bus.creditos !== 4'd15) begin
      n_err++;
      $display("FAIL saturation: got %0d expected 15", bus.creditos);
    end
    for (int i = 0; i < 6; i++) do_op(1);
    n_cmp++;
    if (bus.estado !== 3'd5 || bus.creditos !== 4'd9) begin
      n_err++;
      $display("FAIL six advances: got estado=%0d creditos=%0d expected 5 9", bus.estado, bus.creditos);
    end
    $display("test_saturacion_vuelta estado=%0d creditos=%0d", bus.estado, bus.creditos);
  endtask

  task automatic test_simultaneo();
    for (int i = 0; i < 8; i++) do_op(0);
    do_op(2);
    n_cmp++;
    if (bus.creditos !== 4'd15) begin
      n_err++;
      $display("FAIL simultaneous at max: got creditos=%0d expected 15", bus.creditos);
    end
    do_cancel();
    do_op(1);
    $display("test_simultaneo done");
  endtask

  task automatic preparar_estado3();
    do_cancel();
    for (int i = 0; i < 5; i++) do_op(0);
    for (int i = 0; i < 3; i++) do_op(1);
  endtask

  task automatic test_cancelar_avance();
    preparar_estado3();
    bus.boton_avance = 1'b1;
    tick(5);
    bus.cancelar = 1'b1;
    tick(2);
    n_cmp++;
    if (bus.avance !== 1'b1 || bus.estado !== 3'd3) begin
      n_err++;
      $display("FAIL cancel setup: got avance=%0b estado=%0d expected 1 3", bus.avance, bus.estado);
    end
    tick(1);
    n_cmp++;
    if (bus.estado !== 3'd0 || bus.creditos !== 4'd0 || bus.avance !== 1'b0) begin
      n_err++;
      $display("FAIL cancel in avance: got estado=%0d creditos=%0d avance=%0b expected 0 0 0",
               bus.estado, bus.creditos, bus.avance);
    end
    bus.cancelar = 1'b0;
    bus.boton_avance = 1'b0;
    tick(12);
    m_cred = 0;
    m_est  = 0;
    n_cmp++;
    if (bus.estado !== 3'd0 || bus.creditos !== 4'd0) begin
      n_err++;
      $display("FAIL after cancel: got estado=%0d creditos=%0d expected 0 0", bus.estado, bus.creditos);
    end
    $display("test_cancelar_avance estado=%0d", bus.estado);
  endtask

  task automatic test_rst_avance();
    int i;
    preparar_estado3();
    bus.boton_avance = 1'b1;
    i = 0;
    while (i < 20 && bus.avance !== 1'b1) begin
      tick(1);
      i++;
    end
    n_cmp++;
    if (bus.avance !== 1'b1) begin
      n_err++;
      $display("FAIL rst setup: got avance=%0b expected 1", bus.avance);
    end
    rst = 1'b1;
    bus.boton_avance = 1'b0;
    tick(1);
    n_cmp++;
    if ({bus.estado, bus.avance, bus.credito, bus.creditos} !== 9'd0) begin
      n_err++;
      $display("FAIL rst in avance: got estado=%0d avance=%0b credito=%0b creditos=%0d expected all 0",
               bus.estado, bus.avance, bus.credito, bus.creditos);
    end
    tick(1);
    rst = 1'b0;
    tick(12);
    m_cred = 0;
    m_est  = 0;
    n_cmp++;
    if (bus.estado !== 3'd0) begin
      n_err++;
      $display("FAIL after rst: got estado=%0d expected 0", bus.estado);
    end
    $display("test_rst_avance estado=%0d", bus.estado);
  endtask

  task automatic test_moneda_en_reset();
    bus.moneda = 1'b1;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(10);
    bus.moneda = 1'b0;
    tick(12);
    m_cred = 1;
    m_est  = 0;
    n_cmp++;
    if (bus.creditos !== 4'd1) begin
      n_err++;
      $display("FAIL coin held through reset: got creditos=%0d expected 1", bus.creditos);
    end
    $display("test_moneda_en_reset creditos=%0d", bus.creditos);
  endtask

  task automatic test_aleatorio();
    int t;
    for (int k = 0; k < 40; k++) begin
      t = $urandom_range(0, 9);
      if (t < 4) begin
        do_op(0);
      end else if (t < 7) begin
        do_op(1);
      end else if (t < 9) begin
        do_op(2);
      end else begin
        do_cancel();
        n_cmp++;
        if (bus.creditos !== 4'd0 || bus.estado !== 3'd0) begin
          n_err++;
          $display("FAIL random cancel: got creditos=%0d estado=%0d expected 0 0", bus.creditos, bus.estado);
        end
        $display("op cancel creditos=%0d estado=%0d", bus.creditos, bus.estado);
      end
    end
    n_cmp++;
    if (estado_malo !== 1'b0) begin
      n_err++;
      $display("FAIL estado range: got out-of-range flag %0b expected 0", estado_malo);
    end
  endtask

  initial begin
    bus.moneda       = 1'b0;
    bus.boton_avance = 1'b0;
    bus.cancelar     = 1'b0;
    test_reset();
    test_moneda_limpia();
    test_rebote();
    test_avance();
    test_saturacion_vuelta();
    test_simultaneo();
    test_cancelar_avance();
    test_rst_avance();
    test_moneda_en_reset();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
